shifter_arbiter: RTL and testbench

Shares one product-alignment lane (right shift by shift amount, then conditional invert/complement for negative products) among the nine FMA product requesters. Replaces nine parallel shift/complement copies with a single pipelined lane. Requesters are granted round-robin over a per-requester valid/ready handshake. Results return tagged with the requester index, through a 2-stage elastic pipeline with downstream backpressure.

---
 rtl/fma_pkg.sv | 31 +++
 rtl/align_lane.sv | 41 ++++
 rtl/shifter_arbiter.sv | 164 ++++++++++++++++
 tb/tb_shifter_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared parameters and types for the shared product-alignment lane.
package fma_pkg;

    localparam int SIG_WIDTH   = 23;
    localparam int SHAMT_WIDTH = 6;
    localparam int NUM_REQ     = 9;

    // Product width: two full significands including the hidden bit.
    localparam int PW = 2 * (SIG_WIDTH + 1);
    // Tag width: enough bits to name every requester.
    localparam int TW = $clog2(NUM_REQ);

    // One granted request as held in stage 1.
    typedef struct packed {
        logic [PW-1:0]          s;
        logic [PW-1:0]          c;
        logic [SHAMT_WIDTH-1:0] shamt;
        logic                   sign;
        logic [TW-1:0]          tag;
    } lane_req_t;

    // Round-robin successor of a granted index, wrapping after the last requester.
    function automatic logic [TW-1:0] next_ptr(input logic [TW-1:0] g);
        if (g == TW'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return g + TW'(1);
        end
    endfunction

endpackage

// File: rtl/align_lane.sv
// Combinational product alignment: logical right shift of the sum and carry
// words, then invert (sum) / two's-complement (carry) for negative products.
// The extra LSB of the carry word injects the +1 that completes the sum's
// one's complement, so s + c stays the negated aligned product.
module align_lane
    import fma_pkg::*;
(
    input  logic [PW-1:0]          s,
    input  logic [PW-1:0]          c,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   sign,
    output logic [PW:0]            res_s,
    output logic [PW:0]            res_c
);

    logic [PW-1:0] sb;
    logic [PW-2:0] cb_lo;
    logic [PW-2:0] cb_neg;

    // Shift both words; amounts at or beyond the product width flush to zero.
    always_comb begin
        sb    = '0;
        cb_lo = '0;
        if (shamt >= SHAMT_WIDTH'(PW)) begin
            sb    = '0;
            cb_lo = '0;
        end else begin
            sb    = s >> shamt;
            cb_lo = (PW-1)'(c >> shamt);
        end
    end

    // Sign adjustment; only the low PW-1 carry bits survive into the result,
    // and the low bits of a negation depend only on the low input bits.
    always_comb begin
        cb_neg = ~cb_lo + (PW-1)'(1);
        res_s  = {sign, sign ? ~sb : sb};
        res_c  = {sign & (|cb_lo), sign ? cb_neg : cb_lo, sign};
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter in front of a single two-stage elastic alignment lane
// shared by all FMA product requesters. Results carry the requester index
// and a batch marker on every NUM_REQ-th result.
module shifter_arbiter
    import fma_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*PW-1:0]         req_s,
    input  logic [NUM_REQ*PW-1:0]         req_c,
    input  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt,
    input  logic [NUM_REQ-1:0]            req_sign,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TW-1:0]                 out_tag,
    output logic [PW:0]                   out_s,
    output logic [PW:0]                   out_c,
    output logic                          out_last
);

    logic [TW-1:0] ptr;
    logic [TW-1:0] bcnt;
    logic          s1_valid;
    lane_req_t     s1;

    logic          s2_load;
    logic          s1_accept;
    logic          gnt_any;
    logic [TW-1:0] gnt_idx;
    logic [TW:0]   cand;
    logic          xfer_in;
    lane_req_t     gnt_req;
    logic [PW:0]   lane_s;
    logic [PW:0]   lane_c;

    // Stage 2 takes a new value when it is empty or being drained this cycle;
    // stage 1 may take a new grant when it is empty or moving into stage 2.
    assign s2_load   = !out_valid || out_ready;
    assign s1_accept = !s1_valid || s2_load;
    assign xfer_in   = gnt_any && s1_accept && !rst;
    assign out_last  = out_valid && (bcnt == TW'(NUM_REQ - 1));

    // Find the first valid requester at or after ptr, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (TW+1)'(k);
            if (cand >= (TW+1)'(NUM_REQ)) begin
                cand = cand - (TW+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!gnt_any && req_valid[cand[TW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[TW-1:0];
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

    // Ready goes only to the winner, and only when stage 1 can take it.
    always_comb begin
        req_ready = '0;
        if (xfer_in) begin
            req_ready[gnt_idx] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Select the winner's operands out of the packed request buses.
    always_comb begin
        gnt_req.s     = req_s[gnt_idx*PW +: PW];
        gnt_req.c     = req_c[gnt_idx*PW +: PW];
        gnt_req.shamt = req_shamt[gnt_idx*SHAMT_WIDTH +: SHAMT_WIDTH];
        gnt_req.sign  = req_sign[gnt_idx];
        gnt_req.tag   = gnt_idx;
    end

    // Round-robin pointer moves past the index that just transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer_in) begin
            ptr <= next_ptr(gnt_idx);
        end else begin
            ptr <= ptr;
        end
    end

    // Stage 1: capture the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_accept) begin
            s1_valid <= xfer_in;
            if (xfer_in) begin
                s1 <= gnt_req;
            end else begin
                s1 <= s1;
            end
        end else begin
            s1_valid <= s1_valid;
            s1       <= s1;
        end
    end

    align_lane u_lane (
        .s     (s1.s),
        .c     (s1.c),
        .shamt (s1.shamt),
        .sign  (s1.sign),
        .res_s (lane_s),
        .res_c (lane_c)
    );

    // Stage 2: register the aligned result; hold it while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_s     <= '0;
            out_c     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_tag <= s1.tag;
                out_s   <= lane_s;
                out_c   <= lane_c;
            end else begin
                out_tag <= out_tag;
                out_s   <= out_s;
                out_c   <= out_c;
            end
        end else begin
            out_valid <= out_valid;
            out_tag   <= out_tag;
            out_s     <= out_s;
            out_c     <= out_c;
        end
    end

    // Batch counter: counts delivered results, wrapping every NUM_REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
        end else if (out_valid && out_ready) begin
            if (bcnt == TW'(NUM_REQ - 1)) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + TW'(1);
            end
        end else begin
            bcnt <= bcnt;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: a vector table for the alignment math,
// plus hand-written sequences for arbitration, backpressure and reset.
module tb_shifter_arbiter;
    import fma_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*PW-1:0]          req_s = '0;
    logic [NUM_REQ*PW-1:0]          req_c = '0;
    logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt = '0;
    logic [NUM_REQ-1:0]             req_sign = '0;
    logic                           out_valid;
    logic                           out_ready = 1'b1;
    logic [TW-1:0]                  out_tag;
    logic [PW:0]                    out_s;
    logic [PW:0]                    out_c;
    logic                           out_last;

    shifter_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_s     (req_s),
        .req_c     (req_c),
        .req_shamt (req_shamt),
        .req_sign  (req_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [47:0] s;
        logic [47:0] c;
        logic [5:0]  shamt;
        logic        sign;
        logic [48:0] exp_s;
        logic [48:0] exp_c;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int cyc      = 0;
    int res_cnt  = 0;

    logic [TW-1:0] obs_tag[$];
    logic [PW:0]   obs_s[$];
    logic          obs_last[$];
    int            obs_cyc[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer; out_last must follow a count of results.
    always @(negedge clk) begin
        if (rst) begin
            res_cnt = 0;
        end else if (out_valid && out_ready) begin
            check("out_last_vs_count", {63'd0, out_last}, {63'd0, (res_cnt == 8)});
            obs_tag.push_back(out_tag);
            obs_s.push_back(out_s);
            obs_last.push_back(out_last);
            obs_cyc.push_back(cyc);
            res_cnt = (res_cnt == 8) ? 0 : res_cnt + 1;
        end
    end

    task automatic clear_obs();
        obs_tag.delete();
        obs_s.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    // Called at a negedge: note transfers, move to just after the next posedge,
    // and (in drain mode) withdraw only the requests that were accepted.
    task automatic sample_and_advance(input bit drain);
        logic [NUM_REQ-1:0] xfer;
        xfer = req_valid & req_ready;
        n_xfer += $countones(xfer);
        @(posedge clk);
        #1;
        if (drain) req_valid = req_valid & ~xfer;
    endtask

    task automatic drain_all();
        int guard = 0;
        while (req_valid != '0 && guard < 60) begin
            @(negedge clk);
            sample_and_advance(1'b1);
            guard++;
        end
        check("drain_requests_done", {55'd0, req_valid}, 64'd0);
        repeat (4) begin
            @(negedge clk);
            sample_and_advance(1'b1);
        end
        @(negedge clk);
        check("drain_out_idle", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic fill_simple();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s[i*PW +: PW] = PW'(i + 1);
            req_c[i*PW +: PW] = '0;
            req_shamt[i*SHAMT_WIDTH +: SHAMT_WIDTH] = '0;
            req_sign[i] = 1'b0;
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] oh;

        vecs[0] = '{3, 48'h0000_0000_FF00, 48'h0000_0000_0010, 6'd4,  1'b0, 49'h0_0000_0000_0FF0, 49'h0_0000_0000_0002};
        vecs[1] = '{3, 48'h0000_0000_FF00, 48'h0000_0000_0010, 6'd4,  1'b1, 49'h1_FFFF_FFFF_F00F, 49'h1_FFFF_FFFF_FFFF};
        vecs[2] = '{0, 48'h1234_5678_9ABC, 48'h0000_0000_0003, 6'd0,  1'b0, 49'h0_1234_5678_9ABC, 49'h0_0000_0000_0006};
        vecs[3] = '{8, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd48, 1'b1, 49'h1_FFFF_FFFF_FFFF, 49'h0_0000_0000_0001};
        vecs[4] = '{5, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd63, 1'b0, 49'h0_0000_0000_0000, 49'h0_0000_0000_0000};
        vecs[5] = '{1, 48'h8000_0000_0000, 48'h8000_0000_0000, 6'd47, 1'b0, 49'h0_0000_0000_0001, 49'h0_0000_0000_0002};
        vecs[6] = '{6, 48'h0000_0000_0010, 48'h0000_0000_0000, 6'd1,  1'b1, 49'h1_FFFF_FFFF_FFF7, 49'h0_0000_0000_0001};
        vecs[7] = '{4, 48'h0000_0000_0000, 48'h8000_0000_0001, 6'd0,  1'b1, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF};

        // Reset state, with every requester asking.
        req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", {55'd0, req_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_tag", {60'd0, out_tag}, 64'd0);
        check("rst_out_s", {15'd0, out_s}, 64'd0);
        check("rst_out_c", {15'd0, out_c}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        clear_obs();

        // Vector table: one isolated request each, two-cycle latency.
        for (int v = 0; v < 8; v++) begin
            req_s[vecs[v].idx*PW +: PW] = vecs[v].s;
            req_c[vecs[v].idx*PW +: PW] = vecs[v].c;
            req_shamt[vecs[v].idx*SHAMT_WIDTH +: SHAMT_WIDTH] = vecs[v].shamt;
            req_sign[vecs[v].idx] = vecs[v].sign;
            req_valid = '0;
            req_valid[vecs[v].idx] = 1'b1;
            oh = '0;
            oh[vecs[v].idx] = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), {55'd0, req_ready}, {55'd0, oh});
            sample_and_advance(1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_lat1_valid", v), {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("vec%0d_valid", v), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_tag", v), {60'd0, out_tag}, 64'(vecs[v].idx));
            check($sformatf("vec%0d_s", v), {15'd0, out_s}, {15'd0, vecs[v].exp_s});
            check($sformatf("vec%0d_c", v), {15'd0, out_c}, {15'd0, vecs[v].exp_c});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        clear_obs();

        // Requesters 2 and 7 with ptr at 5: 7 wins, then 2.
        req_valid = 9'b010000100;
        @(negedge clk);
        check("rr_first_grant", {55'd0, req_ready}, 64'h080);
        sample_and_advance(1'b1);
        @(negedge clk);
        check("rr_second_grant", {55'd0, req_ready}, 64'h004);
        sample_and_advance(1'b1);
        drain_all();
        check("rr_count", 64'(obs_tag.size()), 64'd2);
        if (obs_tag.size() == 2) begin
            check("rr_tag0", {60'd0, obs_tag[0]}, 64'd7);
            check("rr_tag1", {60'd0, obs_tag[1]}, 64'd2);
            check("rr_last0_ninth", {63'd0, obs_last[0]}, 64'd1);
        end

        // Reset with both stages full: nothing in flight survives.
        fill_simple();
        out_ready = 1'b0;
        req_valid = '1;
        repeat (2) begin
            @(negedge clk);
            sample_and_advance(1'b1);
        end
        @(negedge clk);
        check("full_stall_ready", {55'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 9'b001001000;
        @(negedge clk);
        check("rst_cycle_ready", {55'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        clear_obs();
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_grant", {55'd0, req_ready}, 64'h008);
        sample_and_advance(1'b1);
        drain_all();
        check("post_rst_count", 64'(obs_tag.size()), 64'd2);
        if (obs_tag.size() == 2) begin
            check("post_rst_tag0", {60'd0, obs_tag[0]}, 64'd3);
            check("post_rst_tag1", {60'd0, obs_tag[1]}, 64'd6);
            check("post_rst_last0", {63'd0, obs_last[0]}, 64'd0);
        end

        // All requesters valid, no backpressure: 0..8 repeating, no bubbles.
        do_reset();
        fill_simple();
        req_valid = '1;
        repeat (20) begin
            @(negedge clk);
            sample_and_advance(1'b0);
        end
        drain_all();
        check("stream_count", 64'(obs_tag.size()), 64'd29);
        for (int i = 0; i < obs_tag.size(); i++) begin
            check($sformatf("stream_tag%0d", i), {60'd0, obs_tag[i]}, 64'(i % 9));
            check($sformatf("stream_last%0d", i), {63'd0, obs_last[i]}, 64'((i % 9) == 8));
            if (i > 0) begin
                check($sformatf("stream_gap%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
            end
        end

        // Backpressure for 5 cycles: exactly 2 accepted, output held.
        do_reset();
        fill_simple();
        out_ready = 1'b0;
        req_valid = '1;
        n_xfer = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("stall%0d_ready", k), {55'd0, req_ready}, 64'd0);
                check($sformatf("stall%0d_valid", k), {63'd0, out_valid}, 64'd1);
                check($sformatf("stall%0d_tag", k), {60'd0, out_tag}, 64'd0);
                check($sformatf("stall%0d_s", k), {15'd0, out_s}, 64'd1);
                check($sformatf("stall%0d_last", k), {63'd0, out_last}, 64'd0);
            end
            sample_and_advance(1'b1);
        end
        check("stall_accepted", 64'(n_xfer), 64'd2);
        out_ready = 1'b1;
        drain_all();
        check("release_count", 64'(obs_tag.size()), 64'd9);
        for (int i = 0; i < obs_tag.size(); i++) begin
            check($sformatf("release_tag%0d", i), {60'd0, obs_tag[i]}, 64'(i));
            check($sformatf("release_s%0d", i), {15'd0, obs_s[i]}, 64'(i + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
